// File: rtl/vq6_dem_ctrl.sv
// Sequencer for a 6-element vector-quantizer DAC with first-order mismatch shaping.
// Latency: out_valid rises SORT_LAT edges after the accept edge.
// Backpressure: one sample in flight; in_ready stays low until out_sel is taken.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready, in_code  input code handshake (code = elements to enable, 7 -> 6)
//   dem_en                      1 = mismatch shaping, 0 = static thermometer (sampled at accept)
//   clr                         clear priorities and sticky flags (honoured in IDLE only)
//   sort_val5..0                priority registers p5..p0 toward the external sorter
//   sort_adr5..0                sorter result, adr5 = index of largest, adr0 = index of smallest
//   out_valid/out_ready/out_sel element-select handshake
//   sat_flag, perm_err          sticky status: priority saturated / bad sorter permutation
module vq6_dem_ctrl #(
    parameter int SW       = 8,
    parameter int SORT_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_code,
    input  logic                 dem_en,
    input  logic                 clr,
    output logic signed [SW-1:0] sort_val5,
    output logic signed [SW-1:0] sort_val4,
    output logic signed [SW-1:0] sort_val3,
    output logic signed [SW-1:0] sort_val2,
    output logic signed [SW-1:0] sort_val1,
    output logic signed [SW-1:0] sort_val0,
    input  logic [2:0]           sort_adr5,
    input  logic [2:0]           sort_adr4,
    input  logic [2:0]           sort_adr3,
    input  logic [2:0]           sort_adr2,
    input  logic [2:0]           sort_adr1,
    input  logic [2:0]           sort_adr0,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [5:0]           out_sel,
    output logic                 sat_flag,
    output logic                 perm_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        OUT    = 2'd2
    } state_t;

    // Update arithmetic runs 4 bits wider than the registers so that
    // p + N - 6 can never wrap before the clamp is applied.
    localparam int WW = SW + 4;
    localparam logic signed [WW-1:0] PMAX = {5'b00000, {(SW-1){1'b1}}};
    localparam logic signed [WW-1:0] PMIN = {5'b11111, {(SW-1){1'b0}}};
    localparam logic signed [WW-1:0] SIX  = WW'(6);

    state_t               state_q;
    state_t               state_d;
    logic [3:0]           cnt_q;
    logic [2:0]           n_q;
    logic                 dem_q;
    logic signed [SW-1:0] p_q [6];

    logic [2:0]           adr [6];
    logic                 perm_bad;
    logic [5:0]           rank_sel;
    logic [5:0]           thermo_sel;
    logic signed [WW-1:0] wide [6];
    logic signed [SW-1:0] p_upd [6];
    logic                 sat_any;
    logic                 accept;
    logic                 settle_done;

    // Priorities go straight to the sorter; no pipeline register in between.
    assign sort_val0 = p_q[0];
    assign sort_val1 = p_q[1];
    assign sort_val2 = p_q[2];
    assign sort_val3 = p_q[3];
    assign sort_val4 = p_q[4];
    assign sort_val5 = p_q[5];

    // adr[r] is the element holding rank r (rank 5 = highest priority).
    assign adr[0] = sort_adr0;
    assign adr[1] = sort_adr1;
    assign adr[2] = sort_adr2;
    assign adr[3] = sort_adr3;
    assign adr[4] = sort_adr4;
    assign adr[5] = sort_adr5;

    assign in_ready    = (state_q == IDLE) && !clr;
    assign out_valid   = (state_q == OUT);
    assign accept      = in_valid && in_ready;
    assign settle_done = (state_q == SETTLE) && (cnt_q == 4'd0);

    // The sorter output must name every element exactly once; anything else
    // (out-of-range index or a repeated index) falls back to thermometer.
    always_comb begin
        perm_bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (adr[i] > 3'd5) begin
                perm_bad = 1'b1;
            end
            for (int j = i + 1; j < 6; j++) begin
                if (adr[i] == adr[j]) begin
                    perm_bad = 1'b1;
                end
            end
        end
    end

    // Enable the elements sitting in the top N ranks. Comparing against each
    // element index keeps an out-of-range address from indexing past bit 5.
    always_comb begin
        rank_sel = '0;
        for (int r = 0; r < 6; r++) begin
            for (int e = 0; e < 6; e++) begin
                if ((r + int'(n_q) >= 6) && (adr[r] == 3'(e))) begin
                    rank_sel[e] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        thermo_sel = 6'b000000;
        case (n_q)
            3'd0:    thermo_sel = 6'b000000;
            3'd1:    thermo_sel = 6'b000001;
            3'd2:    thermo_sel = 6'b000011;
            3'd3:    thermo_sel = 6'b000111;
            3'd4:    thermo_sel = 6'b001111;
            3'd5:    thermo_sel = 6'b011111;
            default: thermo_sel = 6'b111111;
        endcase
    end

    // Each element gains N per sample and loses 6 when used; over the six
    // elements that nets to zero, which is what shapes the mismatch error.
    always_comb begin
        sat_any = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wide[i]  = {{4{p_q[i][SW-1]}}, p_q[i]}
                     + {{(SW+1){1'b0}}, n_q}
                     - (rank_sel[i] ? SIX : '0);
            p_upd[i] = wide[i][SW-1:0];
            if (wide[i] > PMAX) begin
                p_upd[i] = PMAX[SW-1:0];
                sat_any  = 1'b1;
            end else if (wide[i] < PMIN) begin
                p_upd[i] = PMIN[SW-1:0];
                sat_any  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= 4'd0;
            n_q      <= 3'd0;
            dem_q    <= 1'b0;
            out_sel  <= 6'b000000;
            sat_flag <= 1'b0;
            perm_err <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                p_q[i] <= '0;
            end
        end else begin
            if ((state_q == IDLE) && clr) begin
                sat_flag <= 1'b0;
                perm_err <= 1'b0;
                for (int i = 0; i < 6; i++) begin
                    p_q[i] <= '0;
                end
            end

            if (accept) begin
                n_q   <= (in_code == 3'd7) ? 3'd6 : in_code;
                dem_q <= dem_en;
                cnt_q <= 4'(SORT_LAT - 1);
            end

            if ((state_q == SETTLE) && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end

            // Sorter has had SORT_LAT cycles on stable priorities: commit.
            if (settle_done) begin
                if (dem_q && !perm_bad) begin
                    out_sel <= rank_sel;
                    for (int i = 0; i < 6; i++) begin
                        p_q[i] <= p_upd[i];
                    end
                    if (sat_any) begin
                        sat_flag <= 1'b1;
                    end
                end else begin
                    out_sel <= thermo_sel;
                    if (dem_q) begin
                        perm_err <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
